game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// Game sequencing for a one-button box-and-pipe game: tick divider, collision and
// scoring checks, and the IDLE -> PLAYING -> DYING -> OVER flow.
module game_controller #(
  parameter int TICK_DIV  = 833333,
  parameter int BOX_X     = 20,
  parameter int BOX_H     = 4,
  parameter int PIPE_W    = 10,
  parameter int FLOOR_Y   = 116,
  parameter int DEAD_HOLD = 30
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       btn,
  input  logic [6:0] box_y,
  input  logic [7:0] pipe_x,
  input  logic [6:0] gap_top,
  input  logic [6:0] gap_bottom,
  output logic       tick,
  output logic       tap,
  output logic       box_reset,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t cur_state, nxt_state;
  logic [CW-1:0] div_cnt, div_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [7:0] score_nxt;
  logic btn_q, btn_rise;
  logic tick_nxt, tap_nxt, box_reset_nxt;
  logic [8:0] box_bot, pipe_end;
  logic overlap, hit, pass, running;

  assign btn_rise = btn & ~btn_q;
  assign state    = cur_state;

  // Collision geometry is widened to 9 bits so no sum can wrap.
  assign box_bot  = {2'b00, box_y} + 9'(BOX_H) - 9'd1;
  assign pipe_end = {1'b0, pipe_x} + 9'(PIPE_W);
  assign overlap  = ({1'b0, pipe_x} <= 9'(BOX_X)) && (pipe_end > 9'(BOX_X));
  assign hit      = ({2'b00, box_y} >= 9'(FLOOR_Y)) ||
                    (overlap && ((box_y < gap_top) || (box_bot > {2'b00, gap_bottom})));
  assign pass     = (pipe_end == 9'(BOX_X));
  assign running  = (cur_state == PLAYING) || (cur_state == DYING);

  // Decisions on "tick" use the registered pulse, so collision and scoring act
  // on the box/pipe values present during the tick cycle.
  always_comb begin
    nxt_state     = cur_state;
    div_nxt       = div_cnt;
    dead_nxt      = dead_cnt;
    score_nxt     = score;
    tick_nxt      = 1'b0;
    tap_nxt       = 1'b0;
    box_reset_nxt = 1'b0;
    if (running) begin
      tick_nxt = (div_cnt == CW'(TICK_DIV - 1));
      div_nxt  = tick_nxt ? '0 : div_cnt + CW'(1);
    end
    case (cur_state)
      IDLE: begin
        if (btn_rise) begin
          nxt_state     = PLAYING;
          box_reset_nxt = 1'b1;
          score_nxt     = 8'd0;
          div_nxt       = '0;
        end
      end
      PLAYING: begin
        tap_nxt = btn_rise;
        if (tick) begin
          if (hit) begin
            nxt_state = DYING;
            dead_nxt  = '0;
          end else if (pass && (score != 8'hFF)) begin
            score_nxt = score + 8'd1;
          end
        end
      end
      DYING: begin
        if (tick) begin
          dead_nxt = dead_cnt + DW'(1);
          if (dead_nxt == DW'(DEAD_HOLD)) nxt_state = OVER;
        end
      end
      OVER: begin
        if (btn_rise) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      div_cnt   <= '0;
      dead_cnt  <= '0;
      score     <= 8'd0;
      btn_q     <= 1'b0;
      tick      <= 1'b0;
      tap       <= 1'b0;
      box_reset <= 1'b0;
      game_over <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      div_cnt   <= div_nxt;
      dead_cnt  <= dead_nxt;
      score     <= score_nxt;
      btn_q     <= btn;
      tick      <= tick_nxt;
      tap       <= tap_nxt;
      box_reset <= box_reset_nxt;
      game_over <= (nxt_state == OVER);
    end
  end

endmodule
